// File: rtl/row_fifo.sv
// Circular row FIFO with first-word-fall-through head, occupancy, sticky overflow and an
// optional three-row neighbourhood window (enabled by defining ROW_FIFO_WINDOW_EN).
module row_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           d,
    input  logic                       push,
    input  logic                       pop,
    output logic [WIDTH-1:0]           q,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [WIDTH-1:0]           win_prev,
    output logic [WIDTH-1:0]           win_cur,
    output logic [WIDTH-1:0]           win_next,
    output logic                       win_valid
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef ROW_FIFO_WINDOW_EN
    if (DEPTH < 3) begin : g_depth_chk
        $fatal(1, "row_fifo: DEPTH must be at least 3 when the window is enabled");
    end
`else
    if (DEPTH < 1) begin : g_depth_chk
        $fatal(1, "row_fifo: DEPTH must be at least 1");
    end
`endif

    // Wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q;
    logic             push_acc, pop_acc;

    always_comb begin
        pop_acc  = pop && !empty;
        push_acc = push && (!full || pop_acc);
        count_d  = count_q;
        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_acc) begin
                mem_q[wr_ptr_q] <= d;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_acc) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
            if (push && !push_acc) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        count    = count_q;
        overflow = overflow_q;
        q        = empty ? '0 : mem_q[rd_ptr_q];
    end

`ifdef ROW_FIFO_WINDOW_EN
    logic [PW-1:0] idx_cur, idx_next;

    assign idx_cur  = ptr_inc(rd_ptr_q);
    assign idx_next = ptr_inc(idx_cur);

    always_comb begin
        win_valid = (count_q >= CW'(3));
        win_prev  = '0;
        win_cur   = '0;
        win_next  = '0;
        if (win_valid) begin
            win_prev = mem_q[rd_ptr_q];
            win_cur  = mem_q[idx_cur];
            win_next = mem_q[idx_next];
        end
    end
`else
    assign win_valid = 1'b0;
    assign win_prev  = '0;
    assign win_cur   = '0;
    assign win_next  = '0;
`endif

endmodule

// File: tb/tb_row_fifo.sv
// Directed self-checking bench for row_fifo at WIDTH=11, DEPTH=4.
module tb_row_fifo;

    localparam int unsigned WIDTH = 11;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] q, win_prev, win_cur, win_next;
    logic             full, empty, overflow, win_valid;
    logic [CW-1:0]    count;

    int vectors = 0;
    int miscompares = 0;

    row_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .d        (d),
        .push     (push),
        .pop      (pop),
        .q        (q),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .win_prev (win_prev),
        .win_cur  (win_cur),
        .win_next (win_next),
        .win_valid(win_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_op(input logic ps, input logic pp, input logic [WIDTH-1:0] v);
        push = ps;
        pop  = pp;
        d    = v;
        tick();
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        do_op(1'b1, 1'b0, 11'h123);
        // Reset must win over a simultaneous push.
        reset = 1'b1;
        push  = 1'b1;
        d     = 11'h7FF;
        tick();
        reset = 1'b0;
        push  = 1'b0;
        vectors++; if (q !== 11'h000) begin miscompares++; $display("FAIL reset_q: got %h want 000", q); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        vectors++; if (win_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wv: got %b want 0", win_valid); end
        vectors++;
        if ({win_prev, win_cur, win_next} !== '0) begin
            miscompares++;
            $display("FAIL reset_win: got %h %h %h want 000 000 000", win_prev, win_cur, win_next);
        end
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 11'h00C; vals[1] = 11'h0F0; vals[2] = 11'h3FF; vals[3] = 11'h001;
        do_reset();
        do_op(1'b1, 1'b0, vals[0]);
        // First-word fall-through: visible right after the pushing edge.
        vectors++; if (q !== 11'h00C) begin miscompares++; $display("FAIL fwft_q: got %h want 00C", q); end
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL fwft_empty: got %b want 0", empty); end
        for (int i = 1; i < 4; i++) begin
            do_op(1'b1, 1'b0, vals[i]);
            vectors++;
            if (count !== CW'(i + 1)) begin
                miscompares++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1);
            end
        end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", full); end
        vectors++; if (q !== 11'h00C) begin miscompares++; $display("FAIL fill_q: got %h want 00C", q); end
`ifndef ROW_FIFO_WINDOW_EN
        vectors++;
        if ({win_valid, win_prev, win_cur, win_next} !== '0) begin
            miscompares++;
            $display("FAIL win_tied: got %b %h %h %h want all 0", win_valid, win_prev, win_cur,
                     win_next);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (q !== vals[i]) begin
                miscompares++;
                $display("FAIL drain_q[%0d]: got %h want %h", i, q, vals[i]);
            end
            do_op(1'b0, 1'b1, '0);
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b want 1", empty); end
        vectors++; if (q !== 11'h000) begin miscompares++; $display("FAIL drain_q_end: got %h want 000", q); end
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL drain_count: got %0d want 0", count); end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 11'h00C; vals[1] = 11'h0F0; vals[2] = 11'h3FF; vals[3] = 11'h001;
        do_reset();
        for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, vals[i]);
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_pre: got %b want 0", overflow); end
        do_op(1'b1, 1'b0, 11'h555);
        vectors++; if (count !== 4) begin miscompares++; $display("FAIL ovf_count: got %0d want 4", count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (q !== vals[i]) begin
                miscompares++;
                $display("FAIL ovf_drain_q[%0d]: got %h want %h", i, q, vals[i]);
            end
            do_op(1'b0, 1'b1, '0);
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL ovf_empty: got %b want 1", empty); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        do_reset();
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_simul_full();
        logic [WIDTH-1:0] exp [4];
        exp[0] = 11'h002; exp[1] = 11'h003; exp[2] = 11'h004; exp[3] = 11'h2AA;
        do_reset();
        for (int i = 1; i <= 4; i++) do_op(1'b1, 1'b0, WIDTH'(i));
        do_op(1'b1, 1'b1, 11'h2AA);
        vectors++; if (count !== 4) begin miscompares++; $display("FAIL sf_count: got %0d want 4", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL sf_ovf: got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (q !== exp[i]) begin
                miscompares++;
                $display("FAIL sf_drain_q[%0d]: got %h want %h", i, q, exp[i]);
            end
            do_op(1'b0, 1'b1, '0);
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL sf_empty: got %b want 1", empty); end
    endtask

    task automatic test_simul_empty();
        do_reset();
        do_op(1'b0, 1'b1, '0);
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL pe_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL pe_empty: got %b want 1", empty); end
        do_op(1'b1, 1'b1, 11'h111);
        vectors++; if (count !== 1) begin miscompares++; $display("FAIL se_count: got %0d want 1", count); end
        vectors++; if (q !== 11'h111) begin miscompares++; $display("FAIL se_q: got %h want 111", q); end
        do_op(1'b0, 1'b1, '0);
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL se_empty: got %b want 1", empty); end
    endtask

    task automatic test_wrap();
        do_reset();
        do_op(1'b1, 1'b0, 11'h100);
        do_op(1'b1, 1'b0, 11'h101);
        // Steady push+pop at count 2 walks both pointers around the ring several times.
        for (int i = 2; i < 12; i++) begin
            vectors++;
            if (q !== WIDTH'(11'h100 + i - 2)) begin
                miscompares++;
                $display("FAIL wrap_q[%0d]: got %h want %h", i, q, WIDTH'(11'h100 + i - 2));
            end
            do_op(1'b1, 1'b1, WIDTH'(11'h100 + i));
            vectors++;
            if (count !== 2) begin
                miscompares++;
                $display("FAIL wrap_count[%0d]: got %0d want 2", i, count);
            end
        end
        vectors++; if (q !== 11'h10A) begin miscompares++; $display("FAIL wrap_tail0: got %h want 10A", q); end
        do_op(1'b0, 1'b1, '0);
        vectors++; if (q !== 11'h10B) begin miscompares++; $display("FAIL wrap_tail1: got %h want 10B", q); end
        do_op(1'b0, 1'b1, '0);
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

`ifdef ROW_FIFO_WINDOW_EN
    task automatic test_window();
        do_reset();
        do_op(1'b1, 1'b0, 11'h001);
        do_op(1'b1, 1'b0, 11'h002);
        vectors++; if (win_valid !== 1'b0) begin miscompares++; $display("FAIL win_v2: got %b want 0", win_valid); end
        vectors++;
        if ({win_prev, win_cur, win_next} !== '0) begin
            miscompares++;
            $display("FAIL win_zero: got %h %h %h want 000 000 000", win_prev, win_cur, win_next);
        end
        do_op(1'b1, 1'b0, 11'h004);
        vectors++; if (win_valid !== 1'b1) begin miscompares++; $display("FAIL win_v3: got %b want 1", win_valid); end
        vectors++; if (win_prev !== 11'h001) begin miscompares++; $display("FAIL win_prev: got %h want 001", win_prev); end
        vectors++; if (win_cur !== 11'h002) begin miscompares++; $display("FAIL win_cur: got %h want 002", win_cur); end
        vectors++; if (win_next !== 11'h004) begin miscompares++; $display("FAIL win_next: got %h want 004", win_next); end
        do_op(1'b0, 1'b1, '0);
        vectors++; if (win_valid !== 1'b0) begin miscompares++; $display("FAIL win_vpop: got %b want 0", win_valid); end
        vectors++;
        if ({win_prev, win_cur, win_next} !== '0) begin
            miscompares++;
            $display("FAIL win_pop_zero: got %h %h %h want 000 000 000", win_prev, win_cur, win_next);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simul_full();
        test_simul_empty();
        test_wrap();
`ifdef ROW_FIFO_WINDOW_EN
        test_window();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/row_fifo.md
# row_fifo

Parametrised row buffer for the Conway datapath: a DEPTH-entry circular FIFO of WIDTH-bit cell rows with push/pop handshake, occupancy tracking and a sticky overflow flag. It generalises the single write-enabled register into a multi-row store with first-word-fall-through output. It also presents a three-row neighbourhood window (previous/current/next) to the next-generation compute logic.

## Interface
Parameters:
- WIDTH, 11, cells per row (bits per entry)
- DEPTH, 4, number of row entries; at least 3 with ROW_FIFO_WINDOW_EN, at least 1 without

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; takes effect on the rising edge of clk while high
- d  input  WIDTH  row to push
- push  input  1  push request
- pop  input  1  pop request
- q  output  WIDTH  oldest row (head), combinational from storage; 0 when empty
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky; set when a push is dropped
- win_prev, win_cur, win_next  output  WIDTH each  entries at head, head+1, head+2 (mod DEPTH)
- win_valid  output  1  count >= 3

## Operation
- Storage: DEPTH x WIDTH array, write pointer wr_ptr, read pointer rd_ptr, count register.
- Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
- Push accepted = push && (!full || pop_accepted). Accepted push writes d at wr_ptr and advances wr_ptr.
- Pop accepted = pop && !empty. Accepted pop advances rd_ptr.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with push and pop: both accepted; the head is removed and d is written into the freed slot; count stays DEPTH.
- Empty with push and pop: pop ignored, push accepted; count becomes 1.
- Pop while empty: no state change, no error.
- Push while full without pop: d is dropped, overflow set to 1. Overflow stays 1 until reset.
- q, full, empty, count and win_* are derived from registered state only. They have no combinational path from d, push or pop.
- Window: the window entries are read from storage regardless of count. When win_valid is 0, all three win_* outputs are forced to 0.

## Timing
- Reset: on the first rising edge with reset high, wr_ptr, rd_ptr, count and overflow go to 0 and every storage entry is cleared to 0.
- After reset: q = 0, empty = 1, full = 0, count = 0, overflow = 0, win_* = 0, win_valid = 0.
- Reset has priority over push/pop in the same cycle.
- Reset mid-operation discards all contents with no drain.
- Write-to-read latency: a row pushed on edge N appears on q after edge N when the FIFO was empty before that edge.
- full, empty, count and win_valid update on the same edge as the pointers.
- Throughput: one push and one pop per cycle sustained, including at full.

## Configuration
- ROW_FIFO_WINDOW_EN defined:
  - win_prev, win_cur, win_next and win_valid are implemented as described.
  - DEPTH < 3 is a fatal elaboration error.
- ROW_FIFO_WINDOW_EN undefined:
  - Window logic is omitted.
  - win_* and win_valid are tied to 0.
  - DEPTH >= 1 is permitted.
  - All other behaviour is identical.

## Test plan
- Reset (WIDTH=11, DEPTH=4): assert reset for 1 edge -> q=0, empty=1, full=0, count=0, overflow=0.
- Fill and drain: push 11'h00C, 11'h0F0, 11'h3FF, 11'h001 over four cycles -> full=1, count=4, q=11'h00C. Then four pops -> q reads 11'h00C, 11'h0F0, 11'h3FF, 11'h001 in order; empty=1 and q=0 at the end.
- Overflow: with the FIFO full, push 11'h555 without pop -> count stays 4, contents unchanged, overflow=1. Overflow remains 1 after draining and clears only on reset.
- Simultaneous at boundaries:
  - Full, push 11'h2AA with pop -> count=4, head advances, 11'h2AA is popped last.
  - Empty, push 11'h111 with pop -> count=1, q=11'h111.
- Wrap-around: interleave 10 pushes and pops, keeping count between 1 and 3 -> FIFO order is preserved across the pointer wrap, and count is never corrupted.
- Window (ROW_FIFO_WINDOW_EN defined): push 11'h001, 11'h002 -> win_valid=0, win_*=0. Push 11'h004 -> win_valid=1, win_prev=11'h001, win_cur=11'h002, win_next=11'h004. Pop -> win_valid=0.
